// File: rtl/br_pred_pkg.sv
// Shared constants, history entry type and saturating counter update for the gshare predictor.
package br_pred_pkg;

  localparam int CNTW_DEF  = 2;
  localparam int PRT_D_DEF = 256;
  localparam int CNT_MAX   = (1 << CNTW_DEF) - 1;
  localparam int CNT_MIN   = 0;
  localparam int CNT_DEF   = 1 << (CNTW_DEF - 1);
  localparam int TBL_IDX   = $clog2(PRT_D_DEF);
  // Fixed 32-bit instructions: the two byte-offset bits never select a counter.
  localparam int ADDR_OFS  = 2;

  typedef struct packed {
    logic               pred;
    logic [TBL_IDX-1:0] idx;
  } hist_ent_t;

  function automatic logic [7:0] cnt_sat_upd(input logic [7:0] cnt,
                                             input logic       up,
                                             input logic [7:0] cmax);
    if (up) return (cnt >= cmax) ? cmax : cnt + 8'd1;
    return (cnt == 8'd0) ? 8'd0 : cnt - 8'd1;
  endfunction

endpackage

// File: rtl/br_gshare_hash.sv
// Per-slot gshare index generation with GHR chaining across the slots predicted in one cycle.
module br_gshare_hash
  import br_pred_pkg::*;
#(
  parameter int ADDR   = 32,
  parameter int PRT_D  = 256,
  parameter int GHR_W  = 8,
  parameter int SIMBRF = 2
) (
  input  logic [SIMBRF-1:0]                      br_vld_p0,
  input  logic [SIMBRF*ADDR-1:0]                 br_addr,
  input  logic [GHR_W-1:0]                       ghr,
  input  logic [PRT_D-1:0]                       tbl_msb,
  output logic [SIMBRF-1:0][$clog2(PRT_D)-1:0]   idx_p0,
  output logic [SIMBRF-1:0]                      pred_p0,
  output logic [GHR_W-1:0]                       ghr_nxt
);

  localparam int TIDX = $clog2(PRT_D);

  logic [GHR_W-1:0] g;
  logic [TIDX-1:0]  pc_idx;
  logic             unused_addr;

  assign unused_addr = ^br_addr;

  // Each slot sees the history already extended by the predictions of the asserted slots below it.
  always_comb begin
    g       = ghr;
    pc_idx  = '0;
    idx_p0  = '0;
    pred_p0 = '0;
    for (int i = 0; i < SIMBRF; i++) begin
      pc_idx     = br_addr[i*ADDR+ADDR_OFS +: TIDX];
      idx_p0[i]  = pc_idx ^ TIDX'(g);
      pred_p0[i] = tbl_msb[idx_p0[i]];
      if (br_vld_p0[i]) g = (g << 1) | GHR_W'(pred_p0[i]);
    end
    ghr_nxt = g;
  end

endmodule

// File: rtl/br_pred_gshare.sv
// gshare direction predictor: counter table, speculative/architectural GHR and in-flight history FIFO.
// Define BR_PRED_STATS_EN to add the stat_commit / stat_miss counters.
module br_pred_gshare
  import br_pred_pkg::*;
#(
  parameter int ADDR     = 32,
  parameter int CNTW     = 2,
  parameter int PRED_D   = 8,
  parameter int PRT_D    = 256,
  parameter int GHR_W    = 8,
  parameter int SIMBRF   = 2,
  parameter int SIMBRCOM = 2,
  parameter bit OUTREG   = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset_,
  input  logic                     flush_,
  input  logic [SIMBRF-1:0]        br_,
  input  logic [SIMBRF*ADDR-1:0]   br_addr,
  output logic [SIMBRF-1:0]        pred_taken,
  input  logic [SIMBRCOM-1:0]      br_commit_,
  input  logic [SIMBRCOM-1:0]      br_taken_,
  input  logic [SIMBRCOM-1:0]      br_pred_miss_,
`ifdef BR_PRED_STATS_EN
  output logic [31:0]              stat_commit,
  output logic [31:0]              stat_miss,
`endif
  output logic                     busy
);

  localparam int TIDX = $clog2(PRT_D);
  localparam int PW   = (PRED_D > 1) ? $clog2(PRED_D) : 1;
  localparam int OW   = $clog2(PRED_D + 1);
  localparam int CMAX = (1 << CNTW) - 1;
  localparam int CDEF = 1 << (CNTW - 1);

  typedef struct packed {
    logic            pred;
    logic [TIDX-1:0] idx;
  } ent_t;

  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int k);
    int s;
    s = (int'(p) + k) % PRED_D;
    return PW'(s);
  endfunction

  logic [CNTW-1:0]              tbl     [PRT_D];
  logic [CNTW-1:0]              tbl_nxt [PRT_D];
  logic [PRT_D-1:0]             tbl_msb;
  ent_t                         fifo_mem [PRED_D];
  logic [PW-1:0]                rd_ptr, wr_ptr;
  logic [OW-1:0]                occ, occ_nxt;
  logic [GHR_W-1:0]             spec_ghr, arch_ghr, arch_nxt, hash_ghr_nxt;
  logic [SIMBRF-1:0]            br_vld_p0, pred_p0;
  logic [SIMBRF-1:0][TIDX-1:0]  idx_p0;
  logic [SIMBRF-1:0]            we;
  logic [SIMBRF-1:0][PW-1:0]    waddr;
  ent_t [SIMBRF-1:0]            wdata;
  ent_t                         cmt_ent;
  logic [7:0]                   upd;
  int                           n_pop, n_push, free_slots;
  logic                         unused_ok;

  assign br_vld_p0 = ~br_;

  always_comb begin
    for (int k = 0; k < PRT_D; k++) tbl_msb[k] = tbl[k][CNTW-1];
  end

  // Stage p0: predictions read the counters before this cycle's training lands.
  br_gshare_hash #(
    .ADDR   (ADDR),
    .PRT_D  (PRT_D),
    .GHR_W  (GHR_W),
    .SIMBRF (SIMBRF)
  ) u_hash (
    .br_vld_p0 (br_vld_p0),
    .br_addr   (br_addr),
    .ghr       (spec_ghr),
    .tbl_msb   (tbl_msb),
    .idx_p0    (idx_p0),
    .pred_p0   (pred_p0),
    .ghr_nxt   (hash_ghr_nxt)
  );

  // Commits retire oldest-first; updates chain so repeated indices accumulate.
  always_comb begin
    tbl_nxt  = tbl;
    arch_nxt = arch_ghr;
    n_pop    = 0;
    cmt_ent  = '0;
    upd      = '0;
    for (int j = 0; j < SIMBRCOM; j++) begin
      if (!br_commit_[j] && (n_pop < int'(occ))) begin
        cmt_ent              = fifo_mem[ptr_add(rd_ptr, n_pop)];
        upd                  = cnt_sat_upd(8'(tbl_nxt[cmt_ent.idx]), !br_taken_[j], 8'(CMAX));
        tbl_nxt[cmt_ent.idx] = upd[CNTW-1:0];
        arch_nxt             = (arch_nxt << 1) | GHR_W'(!br_taken_[j]);
        n_pop                = n_pop + 1;
      end
    end
  end

  // Pushes beyond the free space are dropped; the prediction itself is still returned.
  always_comb begin
    n_push     = 0;
    free_slots = PRED_D - (int'(occ) - n_pop);
    we         = '0;
    waddr      = '0;
    wdata      = '0;
    for (int i = 0; i < SIMBRF; i++) begin
      waddr[i] = ptr_add(wr_ptr, n_push);
      wdata[i] = '{pred: pred_p0[i], idx: idx_p0[i]};
      if (br_vld_p0[i] && flush_ && (n_push < free_slots)) begin
        we[i]  = 1'b1;
        n_push = n_push + 1;
      end
    end
  end

  assign occ_nxt = flush_ ? OW'(int'(occ) - n_pop + n_push) : '0;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int k = 0; k < PRT_D; k++) tbl[k] <= CNTW'(CDEF);
      spec_ghr <= '0;
      arch_ghr <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      occ      <= '0;
      busy     <= 1'b0;
    end else begin
      tbl      <= tbl_nxt;
      arch_ghr <= arch_nxt;
      spec_ghr <= flush_ ? hash_ghr_nxt : arch_nxt;
      rd_ptr   <= flush_ ? ptr_add(rd_ptr, n_pop) : '0;
      wr_ptr   <= flush_ ? ptr_add(wr_ptr, n_push) : '0;
      occ      <= occ_nxt;
      busy     <= (int'(occ_nxt) > (PRED_D - SIMBRF));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < SIMBRF; i++) begin
      if (we[i]) fifo_mem[waddr[i]] <= wdata[i];
    end
  end

  // Stage p1: optional output register.
  generate
    if (OUTREG) begin : g_outreg
      logic [SIMBRF-1:0] pred_taken_p1;
      always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) pred_taken_p1 <= '0;
        else         pred_taken_p1 <= pred_p0 & br_vld_p0;
      end
      assign pred_taken = pred_taken_p1;
    end else begin : g_outcomb
      assign pred_taken = pred_p0 & br_vld_p0;
    end
  endgenerate

`ifdef BR_PRED_STATS_EN
  function automatic logic [31:0] sat_add32(input logic [31:0] v, input int n);
    logic [32:0] s;
    s = {1'b0, v} + 33'(n);
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  int n_cmt, n_miss;

  always_comb begin
    n_cmt  = 0;
    n_miss = 0;
    for (int j = 0; j < SIMBRCOM; j++) begin
      if (!br_commit_[j]) begin
        n_cmt = n_cmt + 1;
        if (!br_pred_miss_[j]) n_miss = n_miss + 1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      stat_commit <= '0;
      stat_miss   <= '0;
    end else begin
      stat_commit <= sat_add32(stat_commit, n_cmt);
      stat_miss   <= sat_add32(stat_miss, n_miss);
    end
  end

  assign unused_ok = ^{cmt_ent.pred, upd};
`else
  assign unused_ok = ^{cmt_ent.pred, upd, br_pred_miss_};
`endif

endmodule
